// File: rtl/vga_pattern_gen_if.sv
// vga_pattern_gen_if
// Bundles the counters and sync levels that the VGA timing generator hands
// to the pattern generator.
//   pixel_x   : pixel counter within the line (0..454)
//   line_y    : line counter within the frame (0..625)
//   h_sync_in : horizontal sync level, active-low
//   v_sync_in : vertical sync level, active-low
// master = timing generator side, slave = pattern generator side.
interface vga_pattern_gen_if;
    logic [15:0] pixel_x;
    logic [15:0] line_y;
    logic        h_sync_in;
    logic        v_sync_in;

    modport master (output pixel_x, output line_y, output h_sync_in, output v_sync_in);
    modport slave  (input  pixel_x, input  line_y, input  h_sync_in, input  v_sync_in);
endinterface

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
// Pixel-colour stage downstream of the VGA timing generator. Draws colour
// bars and/or a bouncing box, selected by a mode FSM that only changes at the
// frame tick. Two-clock latency from counters/syncs in to colour/syncs out.
// Ports:
//   CLK       : pixel clock (16 MHz)
//   RST_N     : synchronous active-low reset
//   tg        : timing generator bus (pixel_x, line_y, h_sync_in, v_sync_in)
//   mode_next : single-cycle pulse, advance display mode at next frame tick
//   red/green/blue : pixel colour, 0 outside the active area
//   h_sync/v_sync  : syncs delayed to match colour latency
// Build option: define VGA_PATTERN_BORDER_EN to add a white one-pixel border
// around the active area in every mode except OFF.
//
// state     | meaning
// MODE_OFF  | black screen
// MODE_BARS | 8 colour bars
// MODE_BOX  | white bouncing box on black
// MODE_BOTH | bouncing box over colour bars (reset state)
module vga_pattern_gen #(
    parameter int H_ACTIVE = 352,
    parameter int V_ACTIVE = 600,
    parameter int BAR_W    = 44,
    parameter int BOX_W    = 32,
    parameter int BOX_H    = 48,
    parameter int STEP     = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    vga_pattern_gen_if.slave tg,
    input  logic             mode_next,
    output logic             red,
    output logic             green,
    output logic             blue,
    output logic             h_sync,
    output logic             v_sync
);
    localparam logic [15:0] LP_H_ACTIVE = 16'(H_ACTIVE);
    localparam logic [15:0] LP_V_ACTIVE = 16'(V_ACTIVE);
    localparam logic [15:0] LP_BAR_W    = 16'(BAR_W);
    localparam logic [15:0] LP_BOX_W    = 16'(BOX_W);
    localparam logic [15:0] LP_BOX_H    = 16'(BOX_H);
    localparam logic [15:0] LP_STEP     = 16'(STEP);

    typedef enum logic [1:0] {MODE_OFF, MODE_BARS, MODE_BOX, MODE_BOTH} mode_t;

    mode_t       r_mode, w_mode_nxt;
    logic        r_pending, w_pending_nxt;
    logic        w_show_bars, w_show_box;
    logic        w_frame_tick, w_active, w_in_box;
    logic [15:0] r_bar_sub, w_bar_sub;
    logic [2:0]  r_bar_idx, w_bar_idx;
    logic [15:0] r_box_x, r_box_y;
    logic        r_dir_x, r_dir_y;    // 1 = moving towards larger coordinates
    logic [16:0] w_move_x, w_move_y;  // {dir, position} after this tick
    logic        r_s1_active, r_s1_box;
    logic [2:0]  r_s1_bar;
    logic [2:0]  r_rgb, w_rgb;
    logic        r_hs_d1, r_hs_d2, r_vs_d1, r_vs_d2;

    assign w_frame_tick = (tg.pixel_x == 16'd0) && (tg.line_y == LP_V_ACTIVE);
    assign w_active     = (tg.pixel_x < LP_H_ACTIVE) && (tg.line_y < LP_V_ACTIVE);
    assign w_in_box     = (tg.pixel_x >= r_box_x) && (tg.pixel_x < r_box_x + LP_BOX_W) &&
                          (tg.line_y >= r_box_y) && (tg.line_y < r_box_y + LP_BOX_H);

    // Mode FSM: state register
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_mode    <= MODE_BOTH;
            r_pending <= 1'b0;
        end else begin
            r_mode    <= w_mode_nxt;
            r_pending <= w_pending_nxt;
        end
    end

    // Mode FSM: next state. A pulse on the tick cycle itself is kept pending
    // for the following tick, since the current request is consumed here.
    always_comb begin
        w_mode_nxt    = r_mode;
        w_pending_nxt = r_pending | mode_next;
        if (w_frame_tick) begin
            w_pending_nxt = mode_next;
            if (r_pending) begin
                case (r_mode)
                    MODE_OFF:  w_mode_nxt = MODE_BARS;
                    MODE_BARS: w_mode_nxt = MODE_BOX;
                    MODE_BOX:  w_mode_nxt = MODE_BOTH;
                    default:   w_mode_nxt = MODE_OFF;
                endcase
            end
        end
    end

    // Mode FSM: outputs
    always_comb begin
        w_show_bars = (r_mode == MODE_BARS) || (r_mode == MODE_BOTH);
        w_show_box  = (r_mode == MODE_BOX)  || (r_mode == MODE_BOTH);
    end

    // Bar index tracks pixel_x incrementally; relies on pixel_x counting up by
    // one per clock from 0, as the timing generator does.
    always_comb begin
        w_bar_sub = r_bar_sub + 16'd1;
        w_bar_idx = r_bar_idx;
        if (tg.pixel_x == 16'd0) begin
            w_bar_sub = 16'd0;
            w_bar_idx = 3'd0;
        end else if (r_bar_sub == LP_BAR_W - 16'd1) begin
            w_bar_sub = 16'd0;
            w_bar_idx = (r_bar_idx == 3'd7) ? 3'd7 : r_bar_idx + 3'd1;
        end
    end

    function automatic logic [16:0] f_move(input logic [15:0] pos, input logic dir_pos,
                                           input logic [15:0] limit, input logic [15:0] size);
        if (dir_pos) begin
            if (pos + size + LP_STEP <= limit) f_move = {1'b1, pos + LP_STEP};
            else                               f_move = {1'b0, pos - LP_STEP};
        end else begin
            if (pos >= LP_STEP) f_move = {1'b0, pos - LP_STEP};
            else                f_move = {1'b1, pos + LP_STEP};
        end
    endfunction

    assign w_move_x = f_move(r_box_x, r_dir_x, LP_H_ACTIVE, LP_BOX_W);
    assign w_move_y = f_move(r_box_y, r_dir_y, LP_V_ACTIVE, LP_BOX_H);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_box_x   <= 16'd0;
            r_box_y   <= 16'd0;
            r_dir_x   <= 1'b1;
            r_dir_y   <= 1'b1;
            r_bar_sub <= 16'd0;
            r_bar_idx <= 3'd0;
        end else begin
            r_bar_sub <= w_bar_sub;
            r_bar_idx <= w_bar_idx;
            if (w_frame_tick) begin
                {r_dir_x, r_box_x} <= w_move_x;
                {r_dir_y, r_box_y} <= w_move_y;
            end
        end
    end

`ifdef VGA_PATTERN_BORDER_EN
    logic w_border, r_s1_border;
    assign w_border = (tg.pixel_x == 16'd0) || (tg.pixel_x == LP_H_ACTIVE - 16'd1) ||
                      (tg.line_y == 16'd0)  || (tg.line_y == LP_V_ACTIVE - 16'd1);
    always_ff @(posedge CLK) begin
        if (!RST_N) r_s1_border <= 1'b0;
        else        r_s1_border <= w_border;
    end
`endif

    // Colour from stage-1 decisions; border beats box beats bars.
    always_comb begin
        w_rgb = 3'b000;
        if (r_s1_active) begin
            if (w_show_bars) w_rgb = r_s1_bar;
            if (w_show_box && r_s1_box) w_rgb = 3'b111;
`ifdef VGA_PATTERN_BORDER_EN
            if ((r_mode != MODE_OFF) && r_s1_border) w_rgb = 3'b111;
`endif
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_s1_active <= 1'b0;
            r_s1_box    <= 1'b0;
            r_s1_bar    <= 3'd0;
            r_rgb       <= 3'b000;
            r_hs_d1     <= 1'b1;
            r_hs_d2     <= 1'b1;
            r_vs_d1     <= 1'b1;
            r_vs_d2     <= 1'b1;
        end else begin
            r_s1_active <= w_active;
            r_s1_box    <= w_in_box;
            r_s1_bar    <= w_bar_idx;
            r_rgb       <= w_rgb;
            r_hs_d1     <= tg.h_sync_in;
            r_hs_d2     <= r_hs_d1;
            r_vs_d1     <= tg.v_sync_in;
            r_vs_d2     <= r_vs_d1;
        end
    end

    assign {red, green, blue} = r_rgb;
    assign h_sync = r_hs_d2;
    assign v_sync = r_vs_d2;
endmodule

// File: tb/tb_vga_pattern_gen.sv
`timescale 1ns/1ps
module tb_vga_pattern_gen;
    logic CLK = 1'b0;
    logic RST_N;
    logic mode_next;
    logic red, green, blue, h_sync, v_sync;
    int   n_pass = 0;
    int   n_total = 0;
    logic [1:0] pat [8];

    vga_pattern_gen_if tg_if ();

    vga_pattern_gen dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .tg        (tg_if),
        .mode_next (mode_next),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .h_sync    (h_sync),
        .v_sync    (v_sync)
    );

    always #5 CLK = ~CLK;

    task automatic drive(input int px, input int ly);
        tg_if.pixel_x = 16'(px);
        tg_if.line_y  = 16'(ly);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic probe(input string tag, input int px, input int ly, input logic [2:0] exp);
        drive(px, ly);
        step();
        step();
        check(tag, {red, green, blue}, exp);
    endtask

    // Sweep pixel_x up from 0 so the incremental bar counter is valid.
    task automatic sweep(input string tag, input int ly, input int target, input logic [2:0] exp);
        for (int x = 0; x <= target; x++) begin
            drive(x, ly);
            step();
        end
        drive(target + 1, ly);
        step();
        check(tag, {red, green, blue}, exp);
    endtask

    task automatic tick(input logic pulse);
        mode_next = pulse;
        drive(0, 600);
        step();
        mode_next = 1'b0;
        drive(1, 600);
        step();
    endtask

    task automatic pulse();
        drive(200, 610);
        mode_next = 1'b1;
        step();
        mode_next = 1'b0;
        step();
    endtask

    initial begin
        RST_N = 1'b0;
        mode_next = 1'b0;
        tg_if.h_sync_in = 1'b0;
        tg_if.v_sync_in = 1'b0;
        drive(10, 10);
        step();
        step();
        check("rst_rgb", {red, green, blue}, 3'b000);
        check("rst_hs", {2'b00, h_sync}, 3'b001);
        check("rst_vs", {2'b00, v_sync}, 3'b001);

        // Sync delay after release
        pat = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
        RST_N = 1'b1;
        drive(400, 10);
        for (int i = 0; i < 8; i++) begin
            {tg_if.h_sync_in, tg_if.v_sync_in} = pat[i];
            step();
            if (i >= 1) begin
                check("sync_h", {2'b00, h_sync}, {2'b00, pat[i-1][1]});
                check("sync_v", {2'b00, v_sync}, {2'b00, pat[i-1][0]});
            end
        end
        tg_if.h_sync_in = 1'b1;
        tg_if.v_sync_in = 1'b1;

        // Reset state: mode BOTH, box at (0,0)
        probe("both_box", 10, 10, 3'b111);
        sweep("both_bar1", 10, 50, 3'b001);
        probe("both_inactive", 50, 600, 3'b000);

        // Three pulses in one frame -> single advance BOTH->OFF
        pulse();
        pulse();
        pulse();
        probe("pend_no_change", 10, 10, 3'b111);
        tick(1'b0);
        probe("off_box", 10, 10, 3'b000);
        tick(1'b0);
        sweep("off_stays", 10, 50, 3'b000);
        // Pulse on the tick cycle is applied one frame later
        tick(1'b1);
        sweep("tick_pulse_defer", 10, 50, 3'b000);
        tick(1'b0);

        // BARS, box now at (8,8)
        sweep("bars_x0", 10, 0, 3'b000);
        sweep("bars_x44", 10, 44, 3'b001);
        sweep("bars_x351", 10, 351, 3'b111);
        sweep("bars_x352", 10, 352, 3'b000);

        // BOX, fifth tick -> box at (10,10)
        pulse();
        tick(1'b0);
        probe("box_tl", 10, 10, 3'b111);
        probe("box_left", 9, 10, 3'b000);
        probe("box_br", 41, 57, 3'b111);
        probe("box_right", 42, 57, 3'b000);
        probe("box_below", 41, 58, 3'b000);

        for (int t = 0; t < 155; t++) tick(1'b0);
        // 160 ticks -> (320,320)
        probe("box160_l", 320, 320, 3'b111);
        probe("box160_l_out", 319, 320, 3'b000);
        probe("box160_r", 351, 367, 3'b111);
        tick(1'b0);
        // 161 -> x bounces to 318, y 322
        probe("box161_l", 318, 322, 3'b111);
        probe("box161_r", 349, 322, 3'b111);
        probe("box161_r_out", 350, 322, 3'b000);
        tick(1'b0);
        probe("box162_l", 316, 324, 3'b111);
        probe("box162_r_out", 348, 324, 3'b000);

        // Border option, mode BOX
`ifdef VGA_PATTERN_BORDER_EN
        probe("border_box", 0, 300, 3'b111);
`else
        probe("noborder_box", 0, 300, 3'b000);
`endif
        probe("box_bg", 100, 300, 3'b000);
        pulse();
        tick(1'b0);
        pulse();
        tick(1'b0);
        probe("off_border", 0, 300, 3'b000);

        // Mid-frame reset
        RST_N = 1'b0;
        tg_if.h_sync_in = 1'b0;
        tg_if.v_sync_in = 1'b0;
        drive(10, 10);
        step();
        check("mid_rst_rgb", {red, green, blue}, 3'b000);
        check("mid_rst_hs", {2'b00, h_sync}, 3'b001);
        check("mid_rst_vs", {2'b00, v_sync}, 3'b001);
        RST_N = 1'b1;
        tg_if.h_sync_in = 1'b1;
        tg_if.v_sync_in = 1'b1;
        probe("post_rst_box", 5, 5, 3'b111);
        probe("post_rst_out", 40, 5, 3'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
